// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational alu between two requesters
// Optional per-requester accept counters o_cnt0/o_cnt1 are built when ALU_ARB_STAT_EN is defined.
module alu_arbiter #(
    parameter int DWIDTH = 32,
    parameter int FWIDTH = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [DWIDTH-1:0] i_req0_a,
    input  logic [DWIDTH-1:0] i_req0_b,
    input  logic [FWIDTH-1:0] i_req0_func,
    output logic              o_rsp0_valid,
    input  logic              i_rsp0_ready,
    output logic [DWIDTH-1:0] o_rsp0_y,
    output logic              o_rsp0_c,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [DWIDTH-1:0] i_req1_a,
    input  logic [DWIDTH-1:0] i_req1_b,
    input  logic [FWIDTH-1:0] i_req1_func,
    output logic              o_rsp1_valid,
    input  logic              i_rsp1_ready,
    output logic [DWIDTH-1:0] o_rsp1_y,
    output logic              o_rsp1_c,
`ifdef ALU_ARB_STAT_EN
    output logic [15:0]       o_cnt0,
    output logic [15:0]       o_cnt1,
`endif
    output logic [DWIDTH-1:0] o_alu_a,
    output logic [DWIDTH-1:0] o_alu_b,
    output logic [FWIDTH-1:0] o_alu_func,
    input  logic [DWIDTH-1:0] i_alu_y,
    input  logic              i_alu_c
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              owner;
    logic              grant;
    logic              accept;
    logic [DWIDTH-1:0] op_a;
    logic [DWIDTH-1:0] op_b;
    logic [FWIDTH-1:0] op_func;
    logic [DWIDTH-1:0] y0_q;
    logic [DWIDTH-1:0] y1_q;
    logic              c0_q;
    logic              c1_q;

    // Ready is gated by reset so it drops to 0 the moment reset asserts.
    always_comb begin
        state_nxt    = state;
        grant        = 1'b0;
        accept       = 1'b0;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (i_req0_valid && i_req1_valid)
                    grant = ~last_grant;
                else
                    grant = i_req1_valid;
                if (!i_rst) begin
                    o_req0_ready = i_req0_valid && !grant;
                    o_req1_ready = i_req1_valid && grant;
                end
                accept = o_req0_ready || o_req1_ready;
                if (accept)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (owner ? i_rsp1_ready : i_rsp0_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_func    <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            c0_q       <= 1'b0;
            c1_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= grant;
                last_grant <= grant;
                op_a       <= grant ? i_req1_a    : i_req0_a;
                op_b       <= grant ? i_req1_b    : i_req0_b;
                op_func    <= grant ? i_req1_func : i_req0_func;
            end
            // Per-requester result registers keep each response stable while idle.
            if (state == EXEC) begin
                if (owner) begin
                    y1_q <= i_alu_y;
                    c1_q <= i_alu_c;
                end else begin
                    y0_q <= i_alu_y;
                    c0_q <= i_alu_c;
                end
            end
        end
    end

`ifdef ALU_ARB_STAT_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (accept) begin
            if (!grant && cnt0_q != 16'hFFFF)
                cnt0_q <= cnt0_q + 16'd1;
            if (grant && cnt1_q != 16'hFFFF)
                cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign o_cnt0 = cnt0_q;
    assign o_cnt1 = cnt1_q;
`endif

    assign o_alu_a      = op_a;
    assign o_alu_b      = op_b;
    assign o_alu_func   = op_func;
    assign o_rsp0_valid = (state == RESP) && !owner;
    assign o_rsp1_valid = (state == RESP) && owner;
    assign o_rsp0_y     = y0_q;
    assign o_rsp0_c     = c0_q;
    assign o_rsp1_y     = y1_q;
    assign o_rsp1_c     = c1_q;

endmodule
